// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory, with an in-order
// tag FIFO for read-response routing. Optional grant counters: define MEM_ARB_PERF_EN.
module mem_rr_arbiter #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input  logic              i_mem_clk,
    input  logic              i_mem_rst_n,
    input  logic              i_a_vld,
    input  logic              i_a_wen,
    input  logic [ADDR_W-1:0] i_a_addr,
    input  logic [DATA_W-1:0] i_a_din,
    output logic              o_a_rdy,
    output logic              o_a_rsp_vld,
    output logic [DATA_W-1:0] o_a_rsp_data,
    input  logic              i_b_vld,
    input  logic              i_b_wen,
    input  logic [ADDR_W-1:0] i_b_addr,
    input  logic [DATA_W-1:0] i_b_din,
    output logic              o_b_rdy,
    output logic              o_b_rsp_vld,
    output logic [DATA_W-1:0] o_b_rsp_data,
    output logic              o_mem_wen,
    output logic              o_mem_ren,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_din,
    input  logic [DATA_W-1:0] i_mem_dout,
    input  logic              i_mem_vld_out,
    output logic              o_err
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       o_a_gnt_cnt,
    output logic [15:0]       o_b_gnt_cnt
`endif
);

    localparam logic [3:0] MAX_CNT  = 4'(MAX_OUTST);
    localparam logic [2:0] LAST_IDX = 3'(MAX_OUTST - 1);

    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    endfunction

    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]        tag_q, tag_d;
    logic              ptr_q, ptr_d;
    logic              mem_wen_q, mem_wen_d, mem_ren_q, mem_ren_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;
    logic              a_rsp_vld_q, a_rsp_vld_d, b_rsp_vld_q, b_rsp_vld_d;
    logic [DATA_W-1:0] a_rsp_data_q, a_rsp_data_d, b_rsp_data_q, b_rsp_data_d;
    logic              err_q, err_d;
    logic              a_elig_s, b_elig_s, gnt_a_s, gnt_b_s, xfer_s, push_s, pop_s, head_s;

    // Arbitration, tag FIFO bookkeeping and next values of all registered outputs
    always_comb begin
        a_elig_s     = i_a_vld & (i_a_wen | (cnt_q < MAX_CNT));
        b_elig_s     = i_b_vld & (i_b_wen | (cnt_q < MAX_CNT));
        // ptr_q = 1 means B was granted last, so A wins a tie
        gnt_a_s      = a_elig_s & (~b_elig_s | ptr_q);
        gnt_b_s      = b_elig_s & ~gnt_a_s;
        xfer_s       = gnt_a_s | gnt_b_s;
        push_s       = xfer_s & ~(gnt_a_s ? i_a_wen : i_b_wen);
        pop_s        = i_mem_vld_out & (cnt_q != 4'd0);
        head_s       = tag_q[rd_ptr_q];
        ptr_d        = xfer_s ? gnt_b_s : ptr_q;
        tag_d        = tag_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        a_rsp_data_d = a_rsp_data_q;
        b_rsp_data_d = b_rsp_data_q;
        if (push_s) begin
            tag_d[wr_ptr_q] = gnt_b_s;
            wr_ptr_d        = next_idx(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_idx(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + 4'd1;
            2'b01:   cnt_d = cnt_q - 4'd1;
            default: cnt_d = cnt_q;
        endcase
        mem_wen_d = xfer_s & ~push_s;
        mem_ren_d = push_s;
        if (xfer_s) begin
            mem_addr_d = gnt_a_s ? i_a_addr : i_b_addr;
            mem_din_d  = gnt_a_s ? i_a_din : i_b_din;
        end else begin
            mem_addr_d = mem_addr_q;
        end
        a_rsp_vld_d = pop_s & ~head_s;
        b_rsp_vld_d = pop_s & head_s;
        if (a_rsp_vld_d) begin
            a_rsp_data_d = i_mem_dout;
        end else begin
            a_rsp_data_d = a_rsp_data_q;
        end
        if (b_rsp_vld_d) begin
            b_rsp_data_d = i_mem_dout;
        end else begin
            b_rsp_data_d = b_rsp_data_q;
        end
        err_d = err_q | (i_mem_vld_out & (cnt_q == 4'd0));
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_mem_clk) begin
        if (!i_mem_rst_n) begin
            cnt_q        <= 4'd0;
            wr_ptr_q     <= 3'd0;
            rd_ptr_q     <= 3'd0;
            tag_q        <= 8'd0;
            ptr_q        <= 1'b1;
            mem_wen_q    <= 1'b0;
            mem_ren_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            a_rsp_vld_q  <= 1'b0;
            b_rsp_vld_q  <= 1'b0;
            a_rsp_data_q <= '0;
            b_rsp_data_q <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tag_q        <= tag_d;
            ptr_q        <= ptr_d;
            mem_wen_q    <= mem_wen_d;
            mem_ren_q    <= mem_ren_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            a_rsp_vld_q  <= a_rsp_vld_d;
            b_rsp_vld_q  <= b_rsp_vld_d;
            a_rsp_data_q <= a_rsp_data_d;
            b_rsp_data_q <= b_rsp_data_d;
            err_q        <= err_d;
        end
    end

    assign o_a_rdy      = gnt_a_s;
    assign o_b_rdy      = gnt_b_s;
    assign o_mem_wen    = mem_wen_q;
    assign o_mem_ren    = mem_ren_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_din    = mem_din_q;
    assign o_a_rsp_vld  = a_rsp_vld_q;
    assign o_b_rsp_vld  = b_rsp_vld_q;
    assign o_a_rsp_data = a_rsp_data_q;
    assign o_b_rsp_data = b_rsp_data_q;
    assign o_err        = err_q;

`ifdef MEM_ARB_PERF_EN
    logic [15:0] a_gnt_cnt_q, b_gnt_cnt_q;

    // Saturating per-requester grant counters
    always_ff @(posedge i_mem_clk) begin
        if (!i_mem_rst_n) begin
            a_gnt_cnt_q <= 16'd0;
            b_gnt_cnt_q <= 16'd0;
        end else begin
            if (gnt_a_s && (a_gnt_cnt_q != 16'hFFFF)) begin
                a_gnt_cnt_q <= a_gnt_cnt_q + 16'd1;
            end else begin
                a_gnt_cnt_q <= a_gnt_cnt_q;
            end
            if (gnt_b_s && (b_gnt_cnt_q != 16'hFFFF)) begin
                b_gnt_cnt_q <= b_gnt_cnt_q + 16'd1;
            end else begin
                b_gnt_cnt_q <= b_gnt_cnt_q;
            end
        end
    end

    assign o_a_gnt_cnt = a_gnt_cnt_q;
    assign o_b_gnt_cnt = b_gnt_cnt_q;
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scenario bench for mem_rr_arbiter: expected read responses are queued at request time
// and compared when the arbiter routes them back.
module tb_mem_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_vld = 1'b0, a_wen = 1'b0, b_vld = 1'b0, b_wen = 1'b0;
    logic [3:0]  a_addr = 4'd0, b_addr = 4'd0;
    logic [31:0] a_din = 32'd0, b_din = 32'd0;
    logic        a_rdy, b_rdy, a_rsp_vld, b_rsp_vld;
    logic [31:0] a_rsp_data, b_rsp_data;
    logic        mem_wen, mem_ren, mem_vld_out = 1'b0, err;
    logic [3:0]  mem_addr;
    logic [31:0] mem_din, mem_dout = 32'd0;
`ifdef MEM_ARB_PERF_EN
    logic [15:0] a_gnt_cnt, b_gnt_cnt;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [32:0] exp_q[$];
    logic [3:0]  cmd_q[$];
    logic [31:0] rsp_salt = 32'd0;

    always #5 clk = ~clk;

    mem_rr_arbiter dut (
        .i_mem_clk(clk), .i_mem_rst_n(rst_n),
        .i_a_vld(a_vld), .i_a_wen(a_wen), .i_a_addr(a_addr), .i_a_din(a_din),
        .o_a_rdy(a_rdy), .o_a_rsp_vld(a_rsp_vld), .o_a_rsp_data(a_rsp_data),
        .i_b_vld(b_vld), .i_b_wen(b_wen), .i_b_addr(b_addr), .i_b_din(b_din),
        .o_b_rdy(b_rdy), .o_b_rsp_vld(b_rsp_vld), .o_b_rsp_data(b_rsp_data),
        .o_mem_wen(mem_wen), .o_mem_ren(mem_ren), .o_mem_addr(mem_addr), .o_mem_din(mem_din),
        .i_mem_dout(mem_dout), .i_mem_vld_out(mem_vld_out), .o_err(err)
`ifdef MEM_ARB_PERF_EN
        , .o_a_gnt_cnt(a_gnt_cnt), .o_b_gnt_cnt(b_gnt_cnt)
`endif
    );

    // Memory contents as seen by the bench: a salted copy of the address
    function automatic logic [31:0] mem_val(input logic [3:0] addr);
        return rsp_salt | {28'd0, addr};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; a_vld = 1'b0; b_vld = 1'b0; mem_vld_out = 1'b0;
        step(); step();
        rst_n = 1'b1;
        exp_q.delete(); cmd_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        do_reset();
        n_cmp++; if ({mem_wen, mem_ren, a_rsp_vld, b_rsp_vld, err} !== 5'd0) begin n_err++; $display("FAIL reset_ctrl got %b want 00000", {mem_wen, mem_ren, a_rsp_vld, b_rsp_vld, err}); end
        n_cmp++; if ({mem_addr, mem_din, a_rsp_data, b_rsp_data} !== 100'd0) begin n_err++; $display("FAIL reset_data got %h/%h/%h/%h want 0", mem_addr, mem_din, a_rsp_data, b_rsp_data); end
        n_cmp++; if ({a_rdy, b_rdy} !== 2'b00) begin n_err++; $display("FAIL reset_rdy got %b want 00", {a_rdy, b_rdy}); end
    endtask

    task automatic test_single_write();
        a_vld = 1'b1; a_wen = 1'b1; a_addr = 4'd3; a_din = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if ({a_rdy, b_rdy} !== 2'b10) begin n_err++; $display("FAIL single_rdy got %b want 10", {a_rdy, b_rdy}); end
        step();
        a_vld = 1'b0;
        n_cmp++; if ({mem_wen, mem_ren} !== 2'b10) begin n_err++; $display("FAIL single_cmd got %b want 10", {mem_wen, mem_ren}); end
        n_cmp++; if (mem_addr !== 4'd3 || mem_din !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_fields got %h/%h want 3/deadbeef", mem_addr, mem_din); end
        step();
        n_cmp++; if ({mem_wen, mem_ren} !== 2'b00 || mem_addr !== 4'd3) begin n_err++; $display("FAIL single_idle got %b addr %h want 00 addr 3", {mem_wen, mem_ren}, mem_addr); end
    endtask

    task automatic test_back_to_back();
        logic exp_a;
        do_reset();
        a_vld = 1'b1; a_wen = 1'b1; a_addr = 4'd1; a_din = 32'hAAAA_0000;
        b_vld = 1'b1; b_wen = 1'b1; b_addr = 4'd2; b_din = 32'hBBBB_0000;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            #1;
            n_cmp++; if ({a_rdy, b_rdy} !== {exp_a, ~exp_a}) begin n_err++; $display("FAIL b2b_grant%0d got %b want %b", i, {a_rdy, b_rdy}, {exp_a, ~exp_a}); end
            step();
            n_cmp++;
            if (mem_wen !== 1'b1 || mem_addr !== (exp_a ? 4'd1 : 4'd2) || mem_din !== (exp_a ? a_din : b_din)) begin
                n_err++; $display("FAIL b2b_cmd%0d got wen %b %h/%h", i, mem_wen, mem_addr, mem_din);
            end
            if (exp_a) a_din = a_din + 32'd1;
            else b_din = b_din + 32'd1;
        end
        a_vld = 1'b0; b_vld = 1'b0;
        step();
        n_cmp++; if (mem_wen !== 1'b0) begin n_err++; $display("FAIL b2b_stop got %b want 0", mem_wen); end
    endtask

    task automatic test_read_routing();
        int   sent, got;
        logic drove;
        logic [32:0] e;
        do_reset();
        rsp_salt = 32'd0;
        a_vld = 1'b1; a_wen = 1'b0; a_addr = 4'd5;
        #1;
        n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL rd_a_rdy got %b want 1", a_rdy); end
        exp_q.push_back({1'b0, mem_val(4'd5)});
        step();
        a_vld = 1'b0; b_vld = 1'b1; b_wen = 1'b0; b_addr = 4'd9;
        n_cmp++; if (mem_ren !== 1'b1 || mem_addr !== 4'd5) begin n_err++; $display("FAIL rd_a_cmd got ren %b addr %h want 1/5", mem_ren, mem_addr); end
        if (mem_ren) cmd_q.push_back(mem_addr);
        #1;
        n_cmp++; if (b_rdy !== 1'b1) begin n_err++; $display("FAIL rd_b_rdy got %b want 1", b_rdy); end
        exp_q.push_back({1'b1, mem_val(4'd9)});
        step();
        b_vld = 1'b0;
        n_cmp++; if (mem_ren !== 1'b1 || mem_addr !== 4'd9) begin n_err++; $display("FAIL rd_b_cmd got ren %b addr %h want 1/9", mem_ren, mem_addr); end
        if (mem_ren) cmd_q.push_back(mem_addr);
        sent = 0; got = 0;
        for (int c = 0; c < 12 && got < 2; c++) begin
            drove = (c % 2 == 1) && (cmd_q.size() > 0);
            mem_vld_out = drove;
            if (drove) begin mem_dout = mem_val(cmd_q.pop_front()); sent++; end
            step();
            mem_vld_out = 1'b0;
            if (a_rsp_vld || b_rsp_vld || drove) begin
                got++;
                n_cmp++;
                if (!drove || exp_q.size() == 0) begin
                    n_err++; $display("FAIL rd_rsp_timing got a %b b %b drove %b", a_rsp_vld, b_rsp_vld, drove);
                end else begin
                    e = exp_q.pop_front();
                    if ({a_rsp_vld, b_rsp_vld} !== {~e[32], e[32]} || (e[32] ? b_rsp_data : a_rsp_data) !== e[31:0]) begin
                        n_err++; $display("FAIL rd_rsp got a %b b %b data %h/%h want id %b data %h", a_rsp_vld, b_rsp_vld, a_rsp_data, b_rsp_data, e[32], e[31:0]);
                    end
                end
            end
        end
        n_cmp++; if (got != 2 || exp_q.size() != 0) begin n_err++; $display("FAIL rd_count got %0d left %0d want 2/0", got, exp_q.size()); end
        step();
        n_cmp++; if (a_rsp_data !== 32'h5 || b_rsp_data !== 32'h9 || err !== 1'b0) begin n_err++; $display("FAIL rd_hold got %h/%h err %b want 5/9/0", a_rsp_data, b_rsp_data, err); end
    endtask

    task automatic test_outstanding_limit();
        int   got;
        logic drove;
        logic [32:0] e;
        do_reset();
        rsp_salt = 32'hC0DE_0000;
        a_vld = 1'b1; a_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_addr = 4'(i);
            #1;
            n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL lim_rdy%0d got %b want 1", i, a_rdy); end
            exp_q.push_back({1'b0, mem_val(4'(i))});
            step();
            if (mem_ren) cmd_q.push_back(mem_addr);
        end
        a_addr = 4'd4;
        b_vld = 1'b1; b_wen = 1'b1; b_addr = 4'd7; b_din = 32'h1234_5678;
        #1;
        n_cmp++; if ({a_rdy, b_rdy} !== 2'b01) begin n_err++; $display("FAIL lim_full got %b want 01", {a_rdy, b_rdy}); end
        step();
        b_vld = 1'b0;
        n_cmp++; if (mem_wen !== 1'b1 || mem_addr !== 4'd7 || mem_din !== 32'h1234_5678) begin n_err++; $display("FAIL lim_bwr got %b %h/%h", mem_wen, mem_addr, mem_din); end
        mem_vld_out = 1'b1;
        mem_dout = mem_val(cmd_q.pop_front());
        #1;
        n_cmp++; if (a_rdy !== 1'b0) begin n_err++; $display("FAIL lim_pop_same got %b want 0", a_rdy); end
        step();
        mem_vld_out = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (a_rsp_vld !== 1'b1 || a_rsp_data !== e[31:0]) begin n_err++; $display("FAIL lim_rsp0 got %b %h want 1 %h", a_rsp_vld, a_rsp_data, e[31:0]); end
        #1;
        n_cmp++; if (a_rdy !== 1'b1) begin n_err++; $display("FAIL lim_freed got %b want 1", a_rdy); end
        exp_q.push_back({1'b0, mem_val(4'd4)});
        step();
        a_vld = 1'b0;
        if (mem_ren) cmd_q.push_back(mem_addr);
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            drove = (c % 2 == 0) && (cmd_q.size() > 0);
            mem_vld_out = drove;
            if (drove) mem_dout = mem_val(cmd_q.pop_front());
            step();
            mem_vld_out = 1'b0;
            if (a_rsp_vld || b_rsp_vld || drove) begin
                got++;
                n_cmp++;
                if (!drove || exp_q.size() == 0) begin
                    n_err++; $display("FAIL lim_rsp_timing got a %b b %b drove %b", a_rsp_vld, b_rsp_vld, drove);
                end else begin
                    e = exp_q.pop_front();
                    if (a_rsp_vld !== 1'b1 || b_rsp_vld !== 1'b0 || a_rsp_data !== e[31:0]) begin
                        n_err++; $display("FAIL lim_rsp got a %b b %b data %h want %h", a_rsp_vld, b_rsp_vld, a_rsp_data, e[31:0]);
                    end
                end
            end
        end
        n_cmp++; if (got != 4 || exp_q.size() != 0 || err !== 1'b0) begin n_err++; $display("FAIL lim_drain got %0d left %0d err %b want 4/0/0", got, exp_q.size(), err); end
    endtask

    task automatic test_err();
        do_reset();
        mem_vld_out = 1'b1; mem_dout = 32'h0BAD_0BAD;
        step();
        mem_vld_out = 1'b0;
        n_cmp++; if (err !== 1'b1 || a_rsp_vld !== 1'b0 || b_rsp_vld !== 1'b0) begin n_err++; $display("FAIL err_set got err %b a %b b %b want 1/0/0", err, a_rsp_vld, b_rsp_vld); end
        step(); step();
        n_cmp++; if (err !== 1'b1) begin n_err++; $display("FAIL err_hold got %b want 1", err); end
        a_vld = 1'b1; a_wen = 1'b0; a_addr = 4'd1;
        step();
        a_vld = 1'b0; b_vld = 1'b1; b_wen = 1'b0; b_addr = 4'd2;
        step();
        b_vld = 1'b0;
        do_reset();
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL err_clear got %b want 0", err); end
        mem_vld_out = 1'b1;
        step();
        mem_vld_out = 1'b0;
        n_cmp++; if (err !== 1'b1 || a_rsp_vld !== 1'b0 || b_rsp_vld !== 1'b0) begin n_err++; $display("FAIL err_fifo_cleared got err %b a %b b %b want 1/0/0", err, a_rsp_vld, b_rsp_vld); end
    endtask

`ifdef MEM_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        a_wen = 1'b1; b_wen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a_vld = (i < 3); b_vld = (i >= 3);
            step();
        end
        a_vld = 1'b0; b_vld = 1'b0;
        n_cmp++; if (a_gnt_cnt !== 16'd3 || b_gnt_cnt !== 16'd2) begin n_err++; $display("FAIL perf_cnt got %0d/%0d want 3/2", a_gnt_cnt, b_gnt_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_routing();
        test_outstanding_limit();
        test_err();
`ifdef MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
Two-requester round-robin arbiter sharing the single-port 16x32 memory between requester A and requester B. Accepts read/write requests over valid/ready handshakes and drives the memory command port with registered signals. Tracks outstanding reads in order and routes each memory read response back to the requester that issued it. Sits directly between the requester agents and the memory's command/response pins.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 32, memory data width
MAX_OUTST, 4, max outstanding reads (tag FIFO depth, 1..8)

Ports:
i_mem_clk  input  1  clock, all logic on posedge
i_mem_rst_n  input  1  synchronous active-low reset
i_a_vld  input  1  requester A request valid
i_a_wen  input  1  A: 1 = write, 0 = read
i_a_addr  input  ADDR_W  A address
i_a_din  input  DATA_W  A write data
o_a_rdy  output  1  A request accepted this cycle
o_a_rsp_vld  output  1  A read data valid (1-cycle pulse)
o_a_rsp_data  output  DATA_W  A read data
i_b_vld, i_b_wen, i_b_addr, i_b_din, o_b_rdy, o_b_rsp_vld, o_b_rsp_data  same as A, for requester B
o_mem_wen  output  1  memory write enable
o_mem_ren  output  1  memory read enable
o_mem_addr  output  ADDR_W  memory address
o_mem_din  output  DATA_W  memory write data
i_mem_dout  input  DATA_W  memory read data
i_mem_vld_out  input  1  memory read data valid
o_err  output  1  sticky: response with no outstanding read

Behaviour:
- Reset is synchronous. While i_mem_rst_n = 0 at a clock edge, all outputs are 0, the tag FIFO is emptied, the outstanding count is 0, o_err is cleared, and the last-grant pointer is set to B. As a result, A wins the first tie.
- Reset mid-operation discards all outstanding reads. No response is generated for them.
- Handshake: a transfer occurs when vld & rdy. o_x_rdy is combinational from the current vlds, the pointer, and the FIFO state. At most one of o_a_rdy/o_b_rdy is high per cycle. A requester holds vld/wen/addr/din stable until rdy.
- Eligibility:
  - A write is always eligible.
  - A read is eligible only if the outstanding count < MAX_OUTST. A pop in the same cycle does not free a slot.
- Arbitration:
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the one not equal to the pointer.
  - The pointer updates to the granted requester on each transfer and holds otherwise.
  - An ineligible read does not block the other requester.
- Issue: registered, latency 1.
  - The cycle after a transfer, o_mem_wen = wen, o_mem_ren = ~wen, and o_mem_addr/o_mem_din = the request fields.
  - With no transfer, o_mem_wen = o_mem_ren = 0. addr/din hold their last values.
  - Back-to-back grants give back-to-back commands.
- Tag FIFO:
  - On a read transfer, push the requester id (A = 0, B = 1).
  - On i_mem_vld_out, pop the head.
  - Simultaneous push and pop are allowed; the count is unchanged.
  - Pointers wrap modulo MAX_OUTST.
- Response routing: registered, latency 1 from i_mem_vld_out. If the head id is A, o_a_rsp_vld = 1 and o_a_rsp_data = i_mem_dout; likewise for B. rsp_data holds its value between pulses. Responses are strictly in issue order.
- i_mem_vld_out with the FIFO empty: no pop, no rsp_vld, o_err set to 1. o_err stays set until reset.
- No dependence on memory read latency. Any latency ≥ 1 cycle is supported as long as memory responses return in order.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds ports o_a_gnt_cnt and o_b_gnt_cnt (output, 16 bits each).
  - Each counts accepted transfers for its requester.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then A write addr 3 data 32'hDEAD_BEEF alone -> o_a_rdy=1 that cycle; next cycle o_mem_wen=1, o_mem_addr=3, o_mem_din=32'hDEADBEEF; o_mem_ren=0.
- A and B both hold valid writes for 4 cycles -> grants in order A, B, A, B; o_mem_wen=1 for 4 consecutive cycles.
- A reads addr 5 and B reads addr 9, memory returns 32'h5 then 32'h9 -> o_a_rsp_vld with 32'h5, then o_b_rsp_vld with 32'h9, each 1 cycle after i_mem_vld_out.
- With MAX_OUTST=4, A issues 5 reads with no response -> o_a_rdy low on the 5th. A B write is still granted. After one i_mem_vld_out, the 5th read is granted the following cycle.
- i_mem_vld_out pulse with nothing outstanding -> no rsp_vld, o_err=1 and held. Reset with 2 reads outstanding -> FIFO cleared, o_err=0.
- MEM_ARB_PERF_EN defined: 3 A transfers and 2 B transfers -> o_a_gnt_cnt=3, o_b_gnt_cnt=2.
